// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cpu_pkg                                                         |
// | Purpose  : Shared opcode constants and the fetch controller state type.    |
// | Contents : c_op_* opcode values, fetch_state_t enumeration.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned c_op_nop = 0;
  localparam int unsigned c_op_add = 1;
  localparam int unsigned c_op_ldi = 2;
  localparam int unsigned c_op_wro = 3;
  localparam int unsigned c_op_hlt = 4;
  localparam int unsigned c_op_sub = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_timer                                                     |
// | Purpose  : Counts fetch cycles spent waiting for read data.                |
// | Ports    : clk     - clock                                                 |
// |            rst     - asynchronous active-low reset                         |
// |            clear   - synchronous clear of the count                        |
// |            enable  - count this cycle                                      |
// |            expired - this cycle is the TIMEOUT-th waiting cycle            |
// | Params   : TIMEOUT - waiting cycles allowed, 1..255                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Flags the cycle whose miss would make the count reach TIMEOUT, so the
  // controller can leave FETCH on exactly the TIMEOUT-th empty cycle.
  assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                      |
// | Purpose  : Instruction fetch sequencer: fetches a word at pc, presents it  |
// |            to the core for one cycle, advances pc or halts on HLT, and     |
// |            faults when memory does not answer within TIMEOUT cycles.       |
// | Ports    : clk, rst (async active-low), start, step                        |
// |            mem_req/mem_addr -> memory, mem_rvalid/mem_rdata <- memory      |
// |            inst/inst_valid -> core, pc, halted, fault status               |
// | Params   : N (data/address width), OPSIZE (opcode width), TIMEOUT          |
// | Config   : FETCH_CTRL_SINGLE_STEP_EN - when defined, each executed non-HLT |
// |            instruction parks in PAUSE until step=1. When undefined step   |
// |            is ignored and PAUSE is never entered.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned OPSIZE  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] inst,
  output logic         inst_valid,
  output logic [N-1:0] pc,
  output logic         halted,
  output logic         fault
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [N-1:0]      r_pc;
  logic [N-1:0]      w_pc_next;
  logic [N-1:0]      r_inst;
  logic [N-1:0]      w_inst_next;
  logic              w_timer_clear;
  logic              w_timer_en;
  logic              w_timer_expired;
  logic [OPSIZE-1:0] w_opcode;
  logic              w_is_hlt;

`ifndef FETCH_CTRL_SINGLE_STEP_EN
  logic w_unused_step;
  assign w_unused_step = step;
`endif

  assign w_opcode = r_inst[N-1 -: OPSIZE];
  assign w_is_hlt = (w_opcode == OPSIZE'(c_op_hlt));

  // Holding the counter clear outside FETCH gives a zero count on every
  // FETCH entry without tracking the entry edge separately.
  assign w_timer_clear = (r_state != ST_FETCH);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_inst  <= w_inst_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_inst_next  = r_inst;
    w_timer_en   = 1'b0;

    case (r_state)
      ST_IDLE, ST_HALT, ST_FAULT: begin
        if (start) begin
          w_pc_next    = '0;
          w_state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (mem_rvalid) begin
          w_inst_next  = mem_rdata;
          w_state_next = ST_EXEC;
        end else begin
          w_timer_en = 1'b1;
          if (w_timer_expired) begin
            w_state_next = ST_FAULT;
          end
        end
      end

      ST_EXEC: begin
        if (w_is_hlt) begin
          w_state_next = ST_HALT;
        end else begin
          // Natural wrap of the N-bit adder takes all-ones back to zero.
          w_pc_next = r_pc + 1'b1;
`ifdef FETCH_CTRL_SINGLE_STEP_EN
          w_state_next = ST_PAUSE;
`else
          w_state_next = ST_FETCH;
`endif
        end
      end

      ST_PAUSE: begin
`ifdef FETCH_CTRL_SINGLE_STEP_EN
        if (step) begin
          w_state_next = ST_FETCH;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_req    = (r_state == ST_FETCH);
  assign mem_addr   = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign inst_valid = (r_state == ST_EXEC);
  assign halted     = (r_state == ST_HALT);
  assign fault      = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 16: instruction, data and address width.
REQ-002 Parameter OPSIZE, default 4: opcode field width, taken from inst[N-1:N-OPSIZE].
REQ-003 Parameter TIMEOUT, default 15: maximum cycles waiting for mem_rvalid before fault; range 1..255.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level-sampled; (re)starts execution from address 0.
REQ-007 step  in  1  single-step advance pulse; used only with the Configuration macro.
REQ-008 mem_req  out  1  fetch request to program memory.
REQ-009 mem_addr  out  N  fetch address; equals pc.
REQ-010 mem_rvalid  in  1  read data valid; meaningful only while mem_req=1.
REQ-011 mem_rdata  in  N  fetched instruction word.
REQ-012 inst  out  N  instruction presented to the CPU core.
REQ-013 inst_valid  out  1  CPU executes inst in this cycle.
REQ-014 pc  out  N  current program counter.
REQ-015 halted  out  1  HLT instruction retired.
REQ-016 fault  out  1  fetch timeout occurred; sticky.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, PAUSE, HALT and FAULT; one state register.
REQ-018 IDLE: mem_req=0, inst_valid=0; start=1 SHALL set pc=0 and enter FETCH at the next edge.
REQ-019 FETCH: mem_req=1 and mem_addr=pc held stable until mem_rvalid=1 is sampled.
REQ-020 mem_rvalid=1 in the first FETCH cycle SHALL be accepted; minimum start-to-inst_valid latency is 2 cycles.
REQ-021 On accepting mem_rvalid, mem_rdata SHALL be latched into inst and the block SHALL enter EXEC.
REQ-022 mem_rvalid while mem_req=0 SHALL be ignored.
REQ-023 A wait counter SHALL clear on FETCH entry and increment each FETCH cycle without mem_rvalid; reaching TIMEOUT SHALL enter FAULT with fault=1.
REQ-024 EXEC: inst_valid=1 for exactly one cycle; inst held until the next accepted fetch.
REQ-025 In EXEC, opcode 4'd4 (HLT) SHALL enter HALT with pc unchanged; any other opcode SHALL set pc=pc+1 and enter FETCH.
REQ-026 pc increment SHALL wrap modulo 2^N; all-ones SHALL become 0 with no flag.
REQ-027 HALT: halted=1, mem_req=0; start=1 SHALL clear halted, set pc=0 and enter FETCH.
REQ-028 FAULT: mem_req=0, fault=1; start=1 SHALL clear fault, set pc=0 and enter FETCH.
REQ-029 start in FETCH, EXEC or PAUSE SHALL be ignored.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, pc=0, inst=0, inst_valid=0, mem_req=0, halted=0, fault=0 and wait counter=0, including mid-fetch.
REQ-031 The first FETCH after reset release SHALL require start=1.

Configuration
REQ-032 Macro FETCH_CTRL_SINGLE_STEP_EN defined: EXEC of a non-HLT instruction SHALL enter PAUSE instead of FETCH; PAUSE holds mem_req=0 and enters FETCH on the edge where step=1.
REQ-033 Macro undefined: PAUSE SHALL be unreachable and step SHALL be ignored; the port SHALL remain present.

Structure
REQ-034 Package cpu_pkg SHALL hold opcode constants (NOP=0, ADD=1, LDI=2, WRO=3, HLT=4, SUB=5) and the fetch_ctrl state enumeration.
REQ-035 The wait counter SHALL be a sub-module named fetch_timer with clear, enable and expired ports.

Verification
REQ-036 Reset, start=1, memory with zero wait returning 0x2105, 0x2203, 0x4000 -> inst_valid pulses at addresses 0, 1 and 2, then halted=1 with pc=2.
REQ-037 mem_rvalid delayed 3 cycles -> mem_addr stable for 4 cycles and exactly one inst_valid pulse.
REQ-038 mem_rvalid withheld with TIMEOUT=15 -> fault=1 after 15 FETCH cycles; subsequent start=1 -> fault=0 and mem_addr=0.
REQ-039 pc preloaded to 0xFFFF via NOP stream -> next mem_addr=0x0000.
REQ-040 rst=0 asserted while mem_req=1 -> mem_req=0 immediately and no inst_valid pulse after release until start=1.
REQ-041 With FETCH_CTRL_SINGLE_STEP_EN defined, step pulsed every 5 cycles -> exactly one inst_valid pulse per step pulse.
